// File: rtl/hud_pkg.sv
// Shared HUD definitions: the timer state encoding and the limits of the
// two-digit seconds display that the timer and the digit renderer both use.
package hud_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    localparam int MAX_DISPLAY_SECONDS = 99;
    localparam int DIGIT_W             = 10;
    localparam int DIGIT_H             = 13;

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk by CLK_HZ: tick pulses for one cycle on the enabled cycle where the
// counter sits at CLK_HZ-1. clr restarts the second; a disabled counter holds.
module sec_prescaler #(
    parameter int CLK_HZ = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);

    logic [PW-1:0] r_cnt;

    assign tick = en && (r_cnt == TERM);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/game_timer.sv
// Round countdown timer feeding the HUD seconds display.
// Optional GAME_TIMER_FRAME_SYNC_EN: game_duration only updates on frame_start.
module game_timer
    import hud_pkg::*;
#(
    parameter int CLK_HZ        = 25_000_000,
    parameter int ROUND_SECONDS = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       frame_start,
    output logic [6:0] game_duration,
    output logic       running,
    output logic       expired,
    output logic       time_up
);

    generate
        if (CLK_HZ < 2 || ROUND_SECONDS < 1 || ROUND_SECONDS > MAX_DISPLAY_SECONDS) begin : g_bad_param
            $error("game_timer: CLK_HZ must be >= 2 and ROUND_SECONDS in 1..99");
        end
    endgenerate

    localparam logic [6:0] RELOAD = 7'(ROUND_SECONDS);

    timer_state_t r_state, w_state_next;
    logic [6:0]   r_count, w_count_next;
    logic         r_time_up, w_time_up_next;
    logic         w_tick, w_en;

    // start overrides counting so a coincident tick can never decrement the reload
    assign w_en = (r_state == RUNNING) && !pause && !start;

    sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .en   (w_en),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= RELOAD;
            r_time_up <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_time_up <= w_time_up_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_time_up_next = 1'b0;
        if (start) begin
            w_state_next = RUNNING;
            w_count_next = RELOAD;
        end else begin
            case (r_state)
                RUNNING: begin
                    if (pause) begin
                        w_state_next = PAUSED;
                    end else if (w_tick) begin
                        if (r_count <= 7'd1) begin
                            w_count_next   = 7'd0;
                            w_state_next   = EXPIRED;
                            w_time_up_next = 1'b1;
                        end else begin
                            w_count_next = r_count - 7'd1;
                        end
                    end
                end
                PAUSED: begin
                    if (!pause) w_state_next = RUNNING;
                end
                default: ;
            endcase
        end
    end

    assign running = (r_state == RUNNING);
    assign expired = (r_state == EXPIRED);
    assign time_up = r_time_up;

`ifdef GAME_TIMER_FRAME_SYNC_EN
    logic [6:0] r_shadow;

    // The shadow samples the count after this edge's update, so the HUD matches state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= RELOAD;
        end else if (frame_start) begin
            r_shadow <= w_count_next;
        end
    end

    assign game_duration = r_shadow;
`else
    logic w_unused_frame_start;
    assign w_unused_frame_start = frame_start;
    assign game_duration        = r_count;
`endif

endmodule
